// File: rtl/chs_power_ctrl_if.sv
// chs_power_ctrl_if: configuration handshake and applied-output bundle of chs_power_ctrl.
//   master modport: drives chs_conf_valid/chs_conf and observes the applied outputs.
//   slave modport : the controller; consumes the word and drives ready/power/mode/busy/done.
// Optional macro CHS_DROP_ERR_EN adds the sticky chs_err signal.
`timescale 1ns / 1ps

interface chs_power_ctrl_if #(
    parameter int unsigned CONF_W = 8,
    parameter int unsigned PWR_W  = 4
);
    logic              chs_conf_valid;
    logic              chs_conf_ready;
    logic [CONF_W-1:0] chs_conf;
    logic [PWR_W-1:0]  chs_power;
    logic              chs_mode;
    logic              chs_busy;
    logic              chs_done;
`ifdef CHS_DROP_ERR_EN
    logic              chs_err;
`endif

    modport master (
        output chs_conf_valid,
        output chs_conf,
        input  chs_conf_ready,
        input  chs_power,
        input  chs_mode,
        input  chs_busy,
`ifdef CHS_DROP_ERR_EN
        input  chs_err,
`endif
        input  chs_done
    );

    modport slave (
        input  chs_conf_valid,
        input  chs_conf,
        output chs_conf_ready,
        output chs_power,
        output chs_mode,
        output chs_busy,
`ifdef CHS_DROP_ERR_EN
        output chs_err,
`endif
        output chs_done
    );
endinterface

// File: rtl/chs_power_ctrl.sv
// chs_power_ctrl: sequential CHS mode/power controller.
// Accepts a CONF_W-bit word, counts its ones BITS_PER_CYC bits per cycle to form the target
// power, takes the target mode from the LSB (heat=1 / cool=0), then ramps the applied power one
// step per cycle, only switching mode while the applied power is zero.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - chs_power_ctrl_if.slave: chs_conf_valid/chs_conf in; chs_conf_ready, chs_power,
//          chs_mode, chs_busy, chs_done (and chs_err with CHS_DROP_ERR_EN) out.
// Optional macro CHS_DROP_ERR_EN: sticky chs_err flags words offered while not ready.
`timescale 1ns / 1ps

module chs_power_ctrl #(
    parameter int unsigned CONF_W       = 8,
    parameter int unsigned BITS_PER_CYC = 1,
    parameter int unsigned PWR_W        = 4
) (
    input logic              clk,
    input logic              rst,
    chs_power_ctrl_if.slave  bus
);
    localparam int unsigned Beats = CONF_W / BITS_PER_CYC;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    typedef enum logic [1:0] {StIdle, StCount, StRamp} state_e;

    state_e            state_q;
    logic [CONF_W-1:0] shift_q;
    logic [PWR_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   cnt_q;
    logic [PWR_W-1:0]  tpower_q;
    logic              tmode_q;
    logic [PWR_W-1:0]  power_q;
    logic              mode_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;

    // Ones in the low BITS_PER_CYC bits, added to the running count.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < int'(BITS_PER_CYC); i++) begin
            acc_d = acc_d + PWR_W'(shift_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            tpower_q <= '0;
            tmode_q  <= 1'b0;
            power_q  <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // After a done pulse ready is still low for one cycle; raise it here.
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (bus.chs_conf_valid && ready_q) begin
                        shift_q <= bus.chs_conf;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        tmode_q <= bus.chs_conf[0];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StCount;
                    end
                end
                StCount: begin
                    shift_q <= shift_q >> BITS_PER_CYC;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(Beats - 1)) begin
                        tpower_q <= acc_d;
                        state_q  <= StRamp;
                    end
                end
                StRamp: begin
                    if (mode_q != tmode_q) begin
                        // Drain power to zero before the mode is allowed to flip.
                        if (power_q != '0) begin
                            power_q <= power_q - PWR_W'(1);
                        end else begin
                            mode_q <= tmode_q;
                        end
                    end else if (power_q < tpower_q) begin
                        power_q <= power_q + PWR_W'(1);
                    end else if (power_q > tpower_q) begin
                        power_q <= power_q - PWR_W'(1);
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef CHS_DROP_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.chs_conf_valid && !ready_q) begin
            err_q <= 1'b1;
        end
    end

    assign bus.chs_err = err_q;
`endif

    assign bus.chs_conf_ready = ready_q;
    assign bus.chs_power      = power_q;
    assign bus.chs_mode       = mode_q;
    assign bus.chs_busy       = busy_q;
    assign bus.chs_done       = done_q;

endmodule

// File: doc/chs_power_ctrl.md
Name: chs_power_ctrl

Overview:
- Sequential, parametrised successor of the combinational CHS mode/power decoder.
- Accepts a CONF_W-bit configuration word over a valid/ready handshake and counts its ones serially, BITS_PER_CYC bits per cycle, to form the target power.
- Takes the target mode from the word's LSB (heat=1 / cool=0).
- Drives the cooler/heater outputs through a rate-limited ramp that never switches mode while power is non-zero.

Parameters:
- CONF_W, 8, configuration word width; must be a multiple of BITS_PER_CYC.
- BITS_PER_CYC, 1, configuration bits counted per clock (1, 2, 4 or 8 supported).
- PWR_W, 4, power output width; must satisfy 2^PWR_W > CONF_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- chs_conf_valid  input  1  chs_conf holds a new word.
- chs_conf_ready  output  1  block can accept a word (IDLE only).
- chs_conf  input  CONF_W  configuration word (temperature degree).
- chs_power  output  PWR_W  applied power (cooler/heater).
- chs_mode  output  1  applied mode, heat=1 / cool=0.
- chs_busy  output  1  high in COUNT or RAMP.
- chs_done  output  1  one-cycle pulse when the applied outputs reach the target.

Behaviour:
- Reset (async, any state) sets: state=IDLE, chs_power=0, chs_mode=0, chs_busy=0, chs_done=0, chs_conf_ready=1. The internal shift register, counter and target registers are cleared. An in-flight count or ramp is abandoned.
- IDLE:
  - chs_conf_ready=1.
  - On chs_conf_valid && chs_conf_ready: latch chs_conf into the shift register, clear the ones accumulator, and set target_mode=chs_conf[0]. Go to COUNT.
- COUNT:
  - Each cycle, add the popcount of the low BITS_PER_CYC bits to the accumulator, then shift right by BITS_PER_CYC.
  - Lasts exactly CONF_W/BITS_PER_CYC cycles. On the last one, target_power = final sum, then go to RAMP.
  - The accumulator is PWR_W bits and cannot overflow, given the PWR_W constraint.
- RAMP: exactly one action per cycle, evaluated in priority order:
  - chs_mode != target_mode and chs_power > 0: chs_power -= 1.
  - chs_mode != target_mode and chs_power == 0: chs_mode <= target_mode.
  - chs_power < target_power: chs_power += 1.
  - chs_power > target_power: chs_power -= 1.
  - Otherwise (equal, mode matches): chs_done=1 for this cycle, go to IDLE.
- chs_busy=1 in COUNT and RAMP. chs_conf_ready=0 outside IDLE. chs_conf_valid outside IDLE is ignored; the word is not queued.
- Latency from acceptance edge to chs_done: CONF_W/BITS_PER_CYC + (ramp steps) + (1 if mode flips) + 1 cycles.
- A repeated identical word still runs COUNT and spends one RAMP cycle asserting chs_done.
- chs_power never wraps. Mode never changes while chs_power != 0.
- chs_done and chs_conf_ready are never high in the same cycle. chs_conf_ready rises the cycle after chs_done.

Optional Feature:
- Macro: CHS_DROP_ERR_EN.
- Defined:
  - Adds output chs_err (1 bit, reset 0).
  - Set sticky to 1 when chs_conf_valid=1 while state != IDLE (word dropped).
  - Cleared only by rst.
- Undefined: port absent; dropped words are silently ignored; all other behaviour identical.

Test Plan:
- Reset, then word 0xB5 (5 ones, LSB=1) with CONF_W=8, BPC=1:
  - 8 COUNT cycles, then 1 cycle switching chs_mode 0->1 at power 0.
  - Then power steps 1,2,3,4,5 on consecutive cycles, then chs_done pulse.
  - 15 cycles from acceptance to chs_done.
- Follow with 0x0E (3 ones, LSB=0):
  - After COUNT, power steps down 4,3,2,1,0 with mode held at 1.
  - Then mode->0, then power 1,2,3, then chs_done.
  - chs_mode must never change while power != 0.
- Word 0x00:
  - Target 0/cool; outputs ramp to power=0, mode=0; chs_done pulse.
  - Then a second 0x00: exactly 8 COUNT cycles + 1 done cycle, with no output change.
- CONF_W=16, BITS_PER_CYC=4, PWR_W=5, word 0xFFFF:
  - COUNT lasts 4 cycles.
  - Target 16, heat; power reaches 16 (no wrap).
- Assert rst mid-RAMP at power=3:
  - Outputs immediately go to power=0, mode=0, busy=0, ready=1 without waiting for a clock edge.
  - A new word is accepted normally afterward.
- Pulse chs_conf_valid during COUNT:
  - Word ignored; ready stays 0; the original target completes.
  - With CHS_DROP_ERR_EN, chs_err rises the next edge and stays 1 until rst.
